// File: rtl/threshold_programmer_mc.sv
`default_nettype none
// ============================================================================
// threshold_programmer_mc : debounced multi-channel high/low threshold writer.
// Optional build macro THRESH_LOCK_EN adds a synchronised lock input. Rev 1.0
// ============================================================================
module threshold_programmer_mc #(
  parameter int N_SW      = 8,
  parameter int N_CH      = 2,
  parameter int CHW       = 1,
  parameter int MAX_LEVEL = 100,
  parameter int MIN_GAP   = 1,
  parameter int DB_CYCLES = 16
) (
  input  logic              clk_100MHz,
  input  logic              reset,
`ifdef THRESH_LOCK_EN
  input  logic              lock,
`endif
  input  logic              saveH_button,
  input  logic              saveL_button,
  input  logic [CHW-1:0]    ch_sel,
  input  logic [N_SW-1:0]   setup_input,
  output logic [8*N_CH-1:0] high_threshold,
  output logic [8*N_CH-1:0] low_threshold,
  output logic              busy,
  output logic              saved,
  output logic              error,
  output logic [2:0]        error_code
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CHECK  = 2'd1,
    S_COMMIT = 2'd2,
    S_REJECT = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [1:0] btn_raw;
  logic [1:0] req;
  assign btn_raw = {saveL_button, saveH_button};

  // Bit 0 is the save-high button, bit 1 the save-low button.
  for (genvar b = 0; b < 2; b++) begin : g_db
    logic          s1, s2, deb, deb_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
        s1    <= 1'b0;
        s2    <= 1'b0;
        deb   <= 1'b0;
        deb_q <= 1'b0;
        cnt   <= '0;
      end else begin
        s1    <= btn_raw[b];
        s2    <= s1;
        deb_q <= deb;
        if (s2 == deb) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          deb <= s2;
          cnt <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end

    assign req[b] = deb & ~deb_q;
  end

  logic [N_SW-1:0] sw_s1, sw_s2;
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= setup_input;
      sw_s2 <= sw_s1;
    end
  end

  logic locked;
`ifdef THRESH_LOCK_EN
  logic lock_s1, lock_s2;
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      lock_s1 <= 1'b0;
      lock_s2 <= 1'b0;
    end else begin
      lock_s1 <= lock;
      lock_s2 <= lock_s1;
    end
  end
  assign locked = lock_s2;
`else
  assign locked = 1'b0;
`endif

  // Thermometer decode: k ones from the LSB up, nothing else is a valid code.
  logic        sw_valid;
  logic [15:0] sw_k;
  logic [7:0]  sw_value;
  always_comb begin
    sw_valid = 1'b0;
    sw_k     = '0;
    for (int i = 0; i <= N_SW; i++) begin
      if ({1'b0, sw_s2} == (((N_SW+1)'(1) << i) - (N_SW+1)'(1))) begin
        sw_valid = 1'b1;
        sw_k     = 16'(i);
      end
    end
  end
  assign sw_value = 8'((sw_k * 16'(MAX_LEVEL)) / 16'(N_SW));

  logic           cap_h, cap_both, cap_valid;
  logic [7:0]     cap_value;
  logic [CHW-1:0] cap_ch;
  logic [2:0]     cause;
  logic [7:0]     hi_q [N_CH];
  logic [7:0]     lo_q [N_CH];

  logic [7:0] cur_hi, cur_lo;
  always_comb begin
    cur_hi = 8'(MAX_LEVEL);
    cur_lo = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (cap_ch == CHW'(c)) begin
        cur_hi = hi_q[c];
        cur_lo = lo_q[c];
      end
    end
  end

  logic ch_ok, order_ok;
  assign ch_ok = {1'b0, cap_ch} < (CHW+1)'(N_CH);

  always_comb begin
    if (cap_h) order_ok = {1'b0, cap_value} >= ({1'b0, cur_lo} + 9'(MIN_GAP));
    else       order_ok = ({1'b0, cap_value} + 9'(MIN_GAP)) <= {1'b0, cur_hi};
  end

  logic [2:0] check_code;
  always_comb begin
    check_code = 3'd0;
    if (cap_both)        check_code = 3'd3;
    else if (!ch_ok)     check_code = 3'd4;
    else if (!cap_valid) check_code = 3'd1;
    else if (!order_ok)  check_code = 3'd2;
  end

  logic capture;
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      S_IDLE: begin
        if ((|req) && !locked) begin
          capture   = 1'b1;
          state_nxt = S_CHECK;
        end
      end
      S_CHECK:  state_nxt = (check_code == 3'd0) ? S_COMMIT : S_REJECT;
      S_COMMIT: state_nxt = S_IDLE;
      S_REJECT: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      cap_h      <= 1'b0;
      cap_both   <= 1'b0;
      cap_valid  <= 1'b0;
      cap_value  <= '0;
      cap_ch     <= '0;
      cause      <= '0;
      error      <= 1'b0;
      error_code <= '0;
      for (int c = 0; c < N_CH; c++) begin
        hi_q[c] <= 8'(MAX_LEVEL);
        lo_q[c] <= '0;
      end
    end else begin
      if (capture) begin
        cap_h     <= req[0];
        cap_both  <= &req;
        cap_valid <= sw_valid;
        cap_value <= sw_value;
        cap_ch    <= ch_sel;
      end
      if (state == S_CHECK) cause <= check_code;
      if (state == S_COMMIT) begin
        for (int c = 0; c < N_CH; c++) begin
          if (cap_ch == CHW'(c)) begin
            if (cap_h) hi_q[c] <= cap_value;
            else       lo_q[c] <= cap_value;
          end
        end
        error      <= 1'b0;
        error_code <= 3'd0;
      end
      if (state == S_REJECT) begin
        error      <= 1'b1;
        error_code <= cause;
      end
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_pack
    assign high_threshold[8*c +: 8] = hi_q[c];
    assign low_threshold[8*c +: 8]  = lo_q[c];
  end

  assign busy  = (state != S_IDLE);
  assign saved = (state == S_COMMIT);

endmodule
`default_nettype wire

// File: tb/tb_threshold_programmer_mc.sv
`default_nettype none
// Bench for threshold_programmer_mc: directed and randomized saves checked
// against a rule-level model of the committed thresholds and error state.
module tb_threshold_programmer_mc;

  localparam int N_SW = 8, N_CH = 2, CHW = 2, MAX_LEVEL = 100, MIN_GAP = 1, DB = 4;

  logic              clk_100MHz = 1'b0;
  logic              reset = 1'b1;
  logic              saveH_button = 1'b0, saveL_button = 1'b0;
  logic [CHW-1:0]    ch_sel = '0;
  logic [N_SW-1:0]   setup_input = '0;
  logic [8*N_CH-1:0] high_threshold, low_threshold;
  logic              busy, saved, error;
  logic [2:0]        error_code;
`ifdef THRESH_LOCK_EN
  logic              lock = 1'b0;
`endif

  int tests = 0;
  int fails = 0;

  int m_hi [N_CH];
  int m_lo [N_CH];
  bit m_err;
  int m_code;

  always #5 clk_100MHz = ~clk_100MHz;

  threshold_programmer_mc #(
    .N_SW(N_SW), .N_CH(N_CH), .CHW(CHW), .MAX_LEVEL(MAX_LEVEL),
    .MIN_GAP(MIN_GAP), .DB_CYCLES(DB)
  ) dut (
    .clk_100MHz    (clk_100MHz),
    .reset         (reset),
`ifdef THRESH_LOCK_EN
    .lock          (lock),
`endif
    .saveH_button  (saveH_button),
    .saveL_button  (saveL_button),
    .ch_sel        (ch_sel),
    .setup_input   (setup_input),
    .high_threshold(high_threshold),
    .low_threshold (low_threshold),
    .busy          (busy),
    .saved         (saved),
    .error         (error),
    .error_code    (error_code)
  );

  // Switch level, or -1 when the pattern is not a thermometer code.
  function automatic int level_of(input logic [N_SW-1:0] sw);
    for (int k = 0; k <= N_SW; k++)
      if (int'(sw) == (1 << k) - 1) return (k * MAX_LEVEL) / N_SW;
    return -1;
  endfunction

  function automatic logic [8*N_CH-1:0] exp_hi();
    logic [8*N_CH-1:0] r;
    for (int c = 0; c < N_CH; c++) r[8*c +: 8] = 8'(m_hi[c]);
    return r;
  endfunction

  function automatic logic [8*N_CH-1:0] exp_lo();
    logic [8*N_CH-1:0] r;
    for (int c = 0; c < N_CH; c++) r[8*c +: 8] = 8'(m_lo[c]);
    return r;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++) begin
      m_hi[c] = MAX_LEVEL;
      m_lo[c] = 0;
    end
    m_err  = 0;
    m_code = 0;
  endtask

  task automatic model_save(input bit h, input bit l, input logic [N_SW-1:0] sw,
                            input int ch, output int code);
    int v;
    v = level_of(sw);
    if (h && l)         code = 3;
    else if (ch >= N_CH) code = 4;
    else if (v < 0)      code = 1;
    else if (h)          code = (v >= m_lo[ch] + MIN_GAP) ? 0 : 2;
    else                 code = (v + MIN_GAP <= m_hi[ch]) ? 0 : 2;
    if (code == 0) begin
      if (h) m_hi[ch] = v;
      else   m_lo[ch] = v;
      m_err  = 0;
      m_code = 0;
    end else begin
      m_err  = 1;
      m_code = code;
    end
  endtask

  task automatic tick();
    @(posedge clk_100MHz);
    #1;
  endtask

  // Press the selected buttons for `hold` cycles, then let everything settle.
  task automatic run_save(input bit h, input bit l, input logic [N_SW-1:0] sw,
                          input int ch, input int hold, output int pulses);
    pulses       = 0;
    setup_input  = sw;
    ch_sel       = CHW'(ch);
    saveH_button = h;
    saveL_button = l;
    for (int i = 1; i <= hold + 20; i++) begin
      tick();
      if (saved) pulses++;
      if (i == hold) begin
        saveH_button = 1'b0;
        saveL_button = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    model_reset();
    tests++; if (high_threshold !== 16'h6464) begin fails++; $display("FAIL reset_high: got %h expected 6464", high_threshold); end
    tests++; if (low_threshold !== 16'h0000) begin fails++; $display("FAIL reset_low: got %h expected 0000", low_threshold); end
    tests++; if (error !== 1'b0 || error_code !== 3'd0) begin fails++; $display("FAIL reset_error: got %b/%0d expected 0/0", error, error_code); end
    tests++; if (busy !== 1'b0 || saved !== 1'b0) begin fails++; $display("FAIL reset_busy_saved: got %b/%b expected 0/0", busy, saved); end
  endtask

  task automatic test_commit_timing();
    int pulses, pulse_at, code;
    logic [7:0] hi_before, hi_after;
    pulses = 0; pulse_at = -1; hi_before = '0; hi_after = '0;
    setup_input  = 8'h0F;
    ch_sel       = 2'd1;
    saveH_button = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (saved) begin pulses++; pulse_at = i; end
      if (i == 8) hi_before = high_threshold[15:8];
      if (i == 9) hi_after  = high_threshold[15:8];
      if (i == 10) saveH_button = 1'b0;
    end
    model_save(1, 0, 8'h0F, 1, code);
    tests++; if (pulses !== 1 || pulse_at !== DB + 4) begin fails++; $display("FAIL timing_saved: got %0d pulses at %0d expected 1 at %0d", pulses, pulse_at, DB + 4); end
    tests++; if (hi_before !== 8'd100 || hi_after !== 8'd50) begin fails++; $display("FAIL timing_high: got %0d->%0d expected 100->50", hi_before, hi_after); end
    tests++; if (high_threshold[7:0] !== 8'd100) begin fails++; $display("FAIL timing_ch0: got %0d expected 100", high_threshold[7:0]); end
    tests++; if (error !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL timing_flags: got err %b busy %b expected 0 0", error, busy); end
  endtask

  task automatic test_invalid_code();
    int p, code;
    run_save(0, 1, 8'h05, 0, 10, p);
    model_save(0, 1, 8'h05, 0, code);
    tests++; if (error !== 1'b1 || error_code !== 3'd1 || p !== 0) begin fails++; $display("FAIL invalid_reject: got err %b code %0d pulses %0d expected 1 1 0", error, error_code, p); end
    tests++; if (low_threshold !== exp_lo() || high_threshold !== exp_hi()) begin fails++; $display("FAIL invalid_unchanged: got %h/%h expected %h/%h", high_threshold, low_threshold, exp_hi(), exp_lo()); end
    run_save(0, 1, 8'h03, 0, 10, p);
    model_save(0, 1, 8'h03, 0, code);
    tests++; if (low_threshold[7:0] !== 8'd25 || p !== 1) begin fails++; $display("FAIL valid_low: got %0d pulses %0d expected 25 1", low_threshold[7:0], p); end
    tests++; if (error !== 1'b0 || error_code !== 3'd0) begin fails++; $display("FAIL valid_clears_error: got %b/%0d expected 0/0", error, error_code); end
  endtask

  task automatic test_ordering();
    int p, code;
    run_save(1, 0, 8'h0F, 0, 10, p);
    model_save(1, 0, 8'h0F, 0, code);
    tests++; if (high_threshold[7:0] !== 8'd50) begin fails++; $display("FAIL order_setup_high: got %0d expected 50", high_threshold[7:0]); end
    run_save(0, 1, 8'h0F, 0, 10, p);
    model_save(0, 1, 8'h0F, 0, code);
    tests++; if (error_code !== 3'd2 || error !== 1'b1 || p !== 0) begin fails++; $display("FAIL order_gap_reject: got code %0d err %b pulses %0d expected 2 1 0", error_code, error, p); end
    tests++; if (low_threshold[7:0] !== 8'd25) begin fails++; $display("FAIL order_low_kept: got %0d expected 25", low_threshold[7:0]); end
    run_save(0, 1, 8'h07, 0, 10, p);
    model_save(0, 1, 8'h07, 0, code);
    tests++; if (low_threshold[7:0] !== 8'd37 || error !== 1'b0 || p !== 1) begin fails++; $display("FAIL order_accept: got %0d err %b pulses %0d expected 37 0 1", low_threshold[7:0], error, p); end
  endtask

  task automatic test_both_and_range();
    int p, code;
    run_save(1, 1, 8'h0F, 0, 10, p);
    model_save(1, 1, 8'h0F, 0, code);
    tests++; if (error_code !== 3'd3 || error !== 1'b1 || p !== 0) begin fails++; $display("FAIL both_edges: got code %0d err %b pulses %0d expected 3 1 0", error_code, error, p); end
    run_save(1, 0, 8'hFF, 2, 10, p);
    model_save(1, 0, 8'hFF, 2, code);
    tests++; if (error_code !== 3'd4 || p !== 0) begin fails++; $display("FAIL ch_range: got code %0d pulses %0d expected 4 0", error_code, p); end
    tests++; if (high_threshold !== exp_hi() || low_threshold !== exp_lo()) begin fails++; $display("FAIL reject_unchanged: got %h/%h expected %h/%h", high_threshold, low_threshold, exp_hi(), exp_lo()); end
  endtask

  task automatic test_glitch_and_hold();
    int p, code;
    run_save(1, 0, 8'hFF, 0, DB - 1, p);
    tests++; if (p !== 0 || busy !== 1'b0) begin fails++; $display("FAIL glitch_saved: got %0d pulses expected 0", p); end
    tests++; if (high_threshold !== exp_hi() || error !== m_err || int'(error_code) !== m_code) begin fails++; $display("FAIL glitch_state: got %h err %b code %0d expected %h %b %0d", high_threshold, error, error_code, exp_hi(), m_err, m_code); end
    run_save(1, 0, 8'hFF, 0, 60, p);
    model_save(1, 0, 8'hFF, 0, code);
    tests++; if (p !== 1 || high_threshold !== exp_hi()) begin fails++; $display("FAIL held_once: got %0d pulses high %h expected 1 %h", p, high_threshold, exp_hi()); end
    run_save(1, 0, 8'h7F, 0, 10, p);
    model_save(1, 0, 8'h7F, 0, code);
    tests++; if (p !== 1 || high_threshold !== exp_hi()) begin fails++; $display("FAIL repress: got %0d pulses high %h expected 1 %h", p, high_threshold, exp_hi()); end
  endtask

  task automatic test_random();
    int p, code, r, ch, k;
    bit h, l;
    logic [N_SW:0] therm;
    logic [N_SW-1:0] sw;
    for (int n = 0; n < 24; n++) begin
      r = $urandom_range(0, 9);
      h = (r <= 4);
      l = (r == 0) || (r >= 5);
      if ($urandom_range(0, 1) == 1) begin
        k     = $urandom_range(0, N_SW);
        therm = ((N_SW+1)'(1) << k) - (N_SW+1)'(1);
        sw    = therm[N_SW-1:0];
      end else begin
        sw = N_SW'($urandom);
      end
      ch = ($urandom_range(0, 9) == 0) ? $urandom_range(2, 3) : $urandom_range(0, 1);
      run_save(h, l, sw, ch, 10, p);
      model_save(h, l, sw, ch, code);
      tests++; if (p !== ((code == 0) ? 1 : 0)) begin fails++; $display("FAIL rand_saved[%0d]: got %0d expected %0d", n, p, (code == 0) ? 1 : 0); end
      tests++; if (high_threshold !== exp_hi() || low_threshold !== exp_lo()) begin fails++; $display("FAIL rand_thresh[%0d]: got %h/%h expected %h/%h", n, high_threshold, low_threshold, exp_hi(), exp_lo()); end
      tests++; if (error !== m_err || int'(error_code) !== m_code) begin fails++; $display("FAIL rand_error[%0d]: got %b/%0d expected %b/%0d", n, error, error_code, m_err, m_code); end
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    int p;
    found        = 0;
    setup_input  = 8'h01;
    ch_sel       = 2'd0;
    saveL_button = 1'b1;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (busy) found = 1;
    end
    tests++; if (!found) begin fails++; $display("FAIL mid_busy_seen: got 0 expected 1"); end
    reset        = 1'b1;
    saveL_button = 1'b0;
    #1;
    model_reset();
    tests++; if (high_threshold !== exp_hi() || low_threshold !== exp_lo()) begin fails++; $display("FAIL mid_reset_thresh: got %h/%h expected %h/%h", high_threshold, low_threshold, exp_hi(), exp_lo()); end
    tests++; if (busy !== 1'b0 || saved !== 1'b0 || error !== 1'b0 || error_code !== 3'd0) begin fails++; $display("FAIL mid_reset_flags: got %b%b%b/%0d expected 000/0", busy, saved, error, error_code); end
    repeat (2) tick();
    reset = 1'b0;
    p = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (saved) p++;
    end
    tests++; if (p !== 0 || low_threshold !== exp_lo()) begin fails++; $display("FAIL mid_no_commit: got %0d pulses low %h expected 0 %h", p, low_threshold, exp_lo()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_commit_timing();
    test_invalid_code();
    test_ordering();
    test_both_and_range();
    test_glitch_and_hold();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
